// File: rtl/multicycle_ctrl_pkg.sv
// Shared MIPS decode constants and control encodings for the multi-cycle controller.
package mips_defs;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpOri   = 6'b001101;
    localparam logic [5:0] OpLui   = 6'b001111;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpJal   = 6'b000011;

    localparam logic [5:0] FunctAdd = 6'b100000;
    localparam logic [5:0] FunctSub = 6'b100010;
    localparam logic [5:0] FunctSll = 6'b000000;
    localparam logic [5:0] FunctJr  = 6'b001000;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluSub = 4'd1,
        AluOr  = 4'd2,
        AluSll = 4'd3
    } alu_ctr_e;

    typedef enum logic [1:0] {
        PcSrcSeq    = 2'd0,
        PcSrcBranch = 2'd1,
        PcSrcJump   = 2'd2,
        PcSrcReg    = 2'd3
    } pc_src_e;

    typedef enum logic [1:0] {
        RegDstRt = 2'd0,
        RegDstRd = 2'd1,
        RegDstRa = 2'd2
    } reg_dst_e;

    typedef enum logic [1:0] {
        WdSelAlu = 2'd0,
        WdSelMem = 2'd1,
        WdSelPc  = 2'd2
    } wd_sel_e;

    typedef enum logic [1:0] {
        ExtZero = 2'd0,
        ExtSign = 2'd1,
        ExtLui  = 2'd2
    } ext_op_e;

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExeR    = 4'd2,
        StExeI    = 4'd3,
        StWbAlu   = 4'd4,
        StMemAddr = 4'd5,
        StMemRd   = 4'd6,
        StMemWr   = 4'd7,
        StWbMem   = 4'd8,
        StBranch  = 4'd9,
        StJump    = 4'd10
    } state_e;

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Wait-cycle counter for data-memory accesses; flags when the wait budget is spent.
module mem_wait_timer #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // MEM_WAIT_MAX of 0 disables the abort entirely.
    assign timeout = (MEM_WAIT_MAX != 0) && (cnt_q == CNT_W'(MEM_WAIT_MAX));

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: decodes Op/Funct from IR and sequences datapath strobes.
module multicycle_ctrl
    import mips_defs::*;
#(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       Mem_Ready,
    output logic       PC_Write,
    output logic [1:0] PC_Src,
    output logic       IR_Write,
    output logic       Reg_Write,
    output logic [1:0] Reg_Dst,
    output logic [1:0] WD_Sel,
    output logic       ALU_SrcB,
    output logic [1:0] Ext_Op,
    output logic [3:0] ALU_Ctr,
    output logic       Mem_Read,
    output logic       Mem_Write,
    output logic       Instr_Done,
    output logic       Illegal,
    output logic       Mem_Err,
    output logic [3:0] State
);

    state_e state_q, state_d;
    logic   in_mem, timeout, timed_out;

    assign in_mem    = (state_q == StMemRd) || (state_q == StMemWr);
    assign timed_out = in_mem && timeout && !Mem_Ready;

    mem_wait_timer #(
        .MEM_WAIT_MAX(MEM_WAIT_MAX),
        .CNT_W       (CNT_W)
    ) u_mem_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (!in_mem || Mem_Ready || timed_out),
        .count_en(in_mem && !Mem_Ready),
        .timeout (timeout)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        PC_Write   = 1'b0;
        PC_Src     = PcSrcSeq;
        IR_Write   = 1'b0;
        Reg_Write  = 1'b0;
        Reg_Dst    = RegDstRt;
        WD_Sel     = WdSelAlu;
        ALU_SrcB   = 1'b0;
        Ext_Op     = ExtZero;
        ALU_Ctr    = AluAdd;
        Mem_Read   = 1'b0;
        Mem_Write  = 1'b0;
        Instr_Done = 1'b0;
        Illegal    = 1'b0;
        Mem_Err    = 1'b0;

        unique case (state_q)
            StFetch: begin
                IR_Write = 1'b1;
                PC_Write = 1'b1;
                state_d  = StDecode;
            end
            StDecode: begin
                case (Op)
                    OpRtype: begin
                        case (Funct)
                            FunctAdd, FunctSub, FunctSll: state_d = StExeR;
                            FunctJr:                      state_d = StJump;
                            default: begin
                                Illegal = 1'b1;
                                state_d = StFetch;
                            end
                        endcase
                    end
                    OpOri, OpLui: state_d = StExeI;
                    OpLw, OpSw:   state_d = StMemAddr;
                    OpBeq:        state_d = StBranch;
                    OpJ, OpJal:   state_d = StJump;
                    default: begin
                        Illegal = 1'b1;
                        state_d = StFetch;
                    end
                endcase
            end
            StExeR: begin
                case (Funct)
                    FunctSub: ALU_Ctr = AluSub;
                    FunctSll: ALU_Ctr = AluSll;
                    default:  ALU_Ctr = AluAdd;
                endcase
                state_d = StWbAlu;
            end
            StExeI: begin
                ALU_SrcB = 1'b1;
                if (Op == OpLui) begin
                    Ext_Op  = ExtLui;
                    ALU_Ctr = AluAdd;
                end else begin
                    Ext_Op  = ExtZero;
                    ALU_Ctr = AluOr;
                end
                state_d = StWbAlu;
            end
            StWbAlu: begin
                Reg_Write  = 1'b1;
                Reg_Dst    = (Op == OpRtype) ? RegDstRd : RegDstRt;
                Instr_Done = 1'b1;
                state_d    = StFetch;
            end
            StMemAddr: begin
                ALU_SrcB = 1'b1;
                Ext_Op   = ExtSign;
                ALU_Ctr  = AluAdd;
                state_d  = (Op == OpSw) ? StMemWr : StMemRd;
            end
            StMemRd: begin
                if (timed_out) begin
                    Mem_Err = 1'b1;
                    state_d = StFetch;
                end else begin
                    Mem_Read = 1'b1;
                    if (Mem_Ready) state_d = StWbMem;
                end
            end
            StMemWr: begin
                if (timed_out) begin
                    Mem_Err = 1'b1;
                    state_d = StFetch;
                end else begin
                    Mem_Write = 1'b1;
                    if (Mem_Ready) begin
                        Instr_Done = 1'b1;
                        state_d    = StFetch;
                    end
                end
            end
            StWbMem: begin
                Reg_Write  = 1'b1;
                WD_Sel     = WdSelMem;
                Instr_Done = 1'b1;
                state_d    = StFetch;
            end
            StBranch: begin
                ALU_Ctr    = AluSub;
                Ext_Op     = ExtSign;
                PC_Src     = PcSrcBranch;
                PC_Write   = Zero;
                Instr_Done = 1'b1;
                state_d    = StFetch;
            end
            StJump: begin
                PC_Write   = 1'b1;
                Instr_Done = 1'b1;
                if (Op == OpRtype) begin
                    PC_Src = PcSrcReg;
                end else begin
                    PC_Src = PcSrcJump;
                end
                if (Op == OpJal) begin
                    Reg_Write = 1'b1;
                    Reg_Dst   = RegDstRa;
                    WD_Sel    = WdSelPc;
                end
                state_d = StFetch;
            end
            default: state_d = StFetch;
        endcase

        // Held reset silences every strobe so an interrupted access never commits.
        if (!reset) begin
            PC_Write   = 1'b0;
            PC_Src     = PcSrcSeq;
            IR_Write   = 1'b0;
            Reg_Write  = 1'b0;
            Reg_Dst    = RegDstRt;
            WD_Sel     = WdSelAlu;
            ALU_SrcB   = 1'b0;
            Ext_Op     = ExtZero;
            ALU_Ctr    = AluAdd;
            Mem_Read   = 1'b0;
            Mem_Write  = 1'b0;
            Instr_Done = 1'b0;
            Illegal    = 1'b0;
            Mem_Err    = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl with hand-computed expectations.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero, Mem_Ready;
    logic       PC_Write, IR_Write, Reg_Write, ALU_SrcB;
    logic [1:0] PC_Src, Reg_Dst, WD_Sel, Ext_Op;
    logic [3:0] ALU_Ctr, State;
    logic       Mem_Read, Mem_Write, Instr_Done, Illegal, Mem_Err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .MEM_WAIT_MAX(15),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Op        (Op),
        .Funct     (Funct),
        .Zero      (Zero),
        .Mem_Ready (Mem_Ready),
        .PC_Write  (PC_Write),
        .PC_Src    (PC_Src),
        .IR_Write  (IR_Write),
        .Reg_Write (Reg_Write),
        .Reg_Dst   (Reg_Dst),
        .WD_Sel    (WD_Sel),
        .ALU_SrcB  (ALU_SrcB),
        .Ext_Op    (Ext_Op),
        .ALU_Ctr   (ALU_Ctr),
        .Mem_Read  (Mem_Read),
        .Mem_Write (Mem_Write),
        .Instr_Done(Instr_Done),
        .Illegal   (Illegal),
        .Mem_Err   (Mem_Err),
        .State     (State)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Advance one clock and let outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [5:0] op, input logic [5:0] fn);
        Op    = op;
        Funct = fn;
    endtask

    int writes, errs, dones, reads, cyc;

    initial begin
        reset = 1'b0; Op = '0; Funct = '0; Zero = 1'b0; Mem_Ready = 1'b0;
        step(); step();
        check("rst_state", State, 0);
        check("rst_ir_write", IR_Write, 0);
        check("rst_pc_write", PC_Write, 0);
        reset = 1'b1; #1;

        // add $3,$1,$2 with Mem_Ready low
        load(6'b000000, 6'b100000);
        check("add_c1_state", State, 0);
        check("add_c1_ir", IR_Write, 1);
        check("add_c1_pcw", PC_Write, 1);
        check("add_c1_regw", Reg_Write, 0);
        step();
        check("add_c2_state", State, 1);
        check("add_c2_regw", Reg_Write, 0);
        step();
        check("add_c3_state", State, 2);
        check("add_c3_alu", ALU_Ctr, 0);
        check("add_c3_regw", Reg_Write, 0);
        step();
        check("add_c4_state", State, 4);
        check("add_c4_regw", Reg_Write, 1);
        check("add_c4_dst", Reg_Dst, 1);
        check("add_c4_done", Instr_Done, 1);
        step();
        check("add_back_fetch", State, 0);

        // sub: ALU_Ctr=SUB in EXE_R
        load(6'b000000, 6'b100010);
        step(); step();
        check("sub_alu", ALU_Ctr, 1);
        step(); step();

        // ori: zero-extend, OR, rt destination
        load(6'b001101, 6'b000101);
        step(); step();
        check("ori_state", State, 3);
        check("ori_srcb", ALU_SrcB, 1);
        check("ori_ext", Ext_Op, 0);
        check("ori_alu", ALU_Ctr, 2);
        step();
        check("ori_dst", Reg_Dst, 0);
        step();

        // lui: imm<<16, ADD
        load(6'b001111, 6'b000000);
        step(); step();
        check("lui_ext", Ext_Op, 2);
        check("lui_alu", ALU_Ctr, 0);
        step(); step();

        // beq taken
        load(6'b000100, 6'b000000);
        Zero = 1'b1;
        step(); step();
        check("beqt_state", State, 9);
        check("beqt_pcw", PC_Write, 1);
        check("beqt_src", PC_Src, 1);
        check("beqt_done", Instr_Done, 1);
        step();
        // beq not taken
        Zero = 1'b0;
        step(); step();
        check("beqn_pcw", PC_Write, 0);
        check("beqn_done", Instr_Done, 1);
        step();

        // jal
        load(6'b000011, 6'b000000);
        step(); step();
        check("jal_state", State, 10);
        check("jal_pcw", PC_Write, 1);
        check("jal_src", PC_Src, 2);
        check("jal_regw", Reg_Write, 1);
        check("jal_dst", Reg_Dst, 2);
        check("jal_wd", WD_Sel, 2);
        step();

        // jr
        load(6'b000000, 6'b001000);
        step(); step();
        check("jr_src", PC_Src, 3);
        check("jr_regw", Reg_Write, 0);
        step();

        // sw with Mem_Ready never asserted: 15 write cycles then abort
        load(6'b101011, 6'b000000);
        step(); step();
        check("sw_addr_ext", Ext_Op, 1);
        check("sw_addr_srcb", ALU_SrcB, 1);
        step();
        writes = 0; errs = 0; dones = 0; cyc = 0;
        while (State == 4'd7 && cyc < 40) begin
            if (Mem_Write) writes++;
            if (Mem_Err) errs++;
            if (Instr_Done) dones++;
            step();
            cyc++;
        end
        check("swto_writes", writes, 15);
        check("swto_err", errs, 1);
        check("swto_done", dones, 0);
        check("swto_fetch", State, 0);

        // sw completing immediately
        step(); step(); step();
        Mem_Ready = 1'b1; #1;
        check("sw_write", Mem_Write, 1);
        check("sw_done", Instr_Done, 1);
        step();
        Mem_Ready = 1'b0; #1;
        check("sw_fetch", State, 0);

        // lw: 3 wait cycles then ready; 8 cycles total
        load(6'b100011, 6'b000000);
        step(); step();
        check("lw_addr_state", State, 5);
        step();
        reads = 0;
        for (int i = 0; i < 4; i++) begin
            Mem_Ready = (i == 3); #1;
            if (Mem_Read) reads++;
            step();
        end
        Mem_Ready = 1'b0; #1;
        check("lw_reads", reads, 4);
        check("lw_wb_state", State, 8);
        check("lw_wb_regw", Reg_Write, 1);
        check("lw_wb_wd", WD_Sel, 1);
        check("lw_wb_dst", Reg_Dst, 0);
        check("lw_wb_done", Instr_Done, 1);
        step();
        check("lw_fetch", State, 0);

        // reset asserted mid MEM_RD
        step(); step(); step();
        check("rstm_state", State, 6);
        check("rstm_read_before", Mem_Read, 1);
        reset = 1'b0; #1;
        check("rstm_read_forced", Mem_Read, 0);
        check("rstm_regw_forced", Reg_Write, 0);
        step();
        check("rstm_fetch", State, 0);
        check("rstm_ir_forced", IR_Write, 0);
        load(6'b111111, 6'b000000);
        reset = 1'b1;
        step();
        check("ill_state", State, 1);
        check("ill_pulse", Illegal, 1);
        check("ill_done", Instr_Done, 0);
        step();
        check("ill_fetch", State, 0);
        check("ill_clear", Illegal, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
